// File: rtl/serial_popcount_offset_converter.sv
// serial_popcount_offset_converter
// Multi-channel bit-serial ones counter. Each channel counts the ones in a
// frame of SERIAL_INPUT_LENGTH qualified bits. The final count is then mapped
// to a signed word (raw, mid-scale offset or bipolar) and presented for all
// channels at once behind a valid/ready handshake.
module serial_popcount_offset_converter #(
    parameter int SERIAL_INPUT_LENGTH = 64,
    parameter int NUM_CHANNELS        = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [1:0]                                    mode,
    input  logic [NUM_CHANNELS-1:0]                       bit_in,
    input  logic                                          bit_valid,
    output logic                                          busy,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [NUM_CHANNELS*($clog2(SERIAL_INPUT_LENGTH)+2)-1:0] sum_out
);

    localparam int N    = SERIAL_INPUT_LENGTH;
    localparam int C    = NUM_CHANNELS;
    localparam int CW   = $clog2(N);
    localparam int CNTW = CW + 1;
    localparam int OW   = CW + 2;

    // Offsets subtracted in mid-scale and bipolar modes, sized to the output word.
    localparam logic [OW-1:0] HALF_OFFSET = OW'(N / 2);
    localparam logic [OW-1:0] FULL_OFFSET = OW'(N);
    // Bit counter value while the final bit of a frame is being accepted.
    localparam logic [CW-1:0] LAST_BIT    = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Maps a final count to its signed output word. Mode 11 behaves as raw.
    // The count is zero-extended by one bit, so 2*cnt never loses its MSB.
    function automatic logic [OW-1:0] offset_apply(
        input logic [CNTW-1:0] cnt,
        input logic [1:0]      md
    );
        logic [OW-1:0] ext;
        logic [OW-1:0] res;
        ext = {1'b0, cnt};
        case (md)
            2'b01:   res = ext - HALF_OFFSET;
            2'b10:   res = {ext[OW-2:0], 1'b0} - FULL_OFFSET;
            2'b00:   res = ext;
            default: res = ext;
        endcase
        return res;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic                busy_r;
    logic                out_valid_r;
    logic                busy_nxt_s;
    logic                out_valid_nxt_s;
    logic [1:0]          mode_r;
    logic [CW-1:0]       bit_cnt_r;
    logic [CNTW-1:0]     count_r     [C];
    logic [CNTW-1:0]     count_inc_s [C];
    logic [C*OW-1:0]     sum_out_r;
    logic [C*OW-1:0]     sum_nxt_s;

    logic                frame_open_s;
    logic                accept_bit_s;
    logic                last_bit_s;

    // A new frame opens from IDLE, or from HOLD when the result is taken in
    // the same cycle (back-to-back frames without an idle bubble).
    assign frame_open_s = start && ((state_r == ST_IDLE) ||
                                    ((state_r == ST_HOLD) && out_ready));
    assign accept_bit_s = (state_r == ST_ACCUM) && bit_valid;
    assign last_bit_s   = accept_bit_s && (bit_cnt_r == LAST_BIT);

    // State register together with the registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= busy_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Next-state decision for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_nxt_s = ST_ACCUM;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs for the upcoming state, registered alongside it.
    always_comb begin
        busy_nxt_s      = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s      = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
            ST_ACCUM: begin
                busy_nxt_s      = 1'b1;
                out_valid_nxt_s = 1'b0;
            end
            ST_HOLD: begin
                busy_nxt_s      = 1'b1;
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s      = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Per-channel count including the bit on the wire, and its mapped result.
    always_comb begin
        sum_nxt_s = '0;
        for (int i = 0; i < C; i++) begin
            count_inc_s[i] = count_r[i] + {{CW{1'b0}}, bit_in[i]};
            sum_nxt_s[i*OW +: OW] = offset_apply(count_inc_s[i], mode_r);
        end
    end

    // Frame datapath: clear and latch mode on frame open, accumulate valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= 2'b00;
            bit_cnt_r <= '0;
            for (int i = 0; i < C; i++) begin
                count_r[i] <= '0;
            end
        end else if (frame_open_s) begin
            mode_r    <= mode;
            bit_cnt_r <= '0;
            for (int i = 0; i < C; i++) begin
                count_r[i] <= '0;
            end
        end else if (accept_bit_s) begin
            mode_r    <= mode_r;
            bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            for (int i = 0; i < C; i++) begin
                count_r[i] <= count_inc_s[i];
            end
        end else begin
            mode_r    <= mode_r;
            bit_cnt_r <= bit_cnt_r;
            for (int i = 0; i < C; i++) begin
                count_r[i] <= count_r[i];
            end
        end
    end

    // Result register: captured with the final bit, held until the next frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_out_r <= '0;
        end else if (last_bit_s) begin
            sum_out_r <= sum_nxt_s;
        end else begin
            sum_out_r <= sum_out_r;
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign sum_out   = sum_out_r;

endmodule

// File: tb/tb_serial_popcount_offset_converter.sv
// Self-checking bench for serial_popcount_offset_converter: directed table
// vectors, gap/backpressure/reset sequences and randomized frames on the
// default configuration, plus end-point sweeps on N=4/C=1 and N=256/C=8.
module tb_serial_popcount_offset_converter;

    logic        clk = 1'b0;
    logic        rst;

    // Default instance: N=64, C=4, OW=8
    logic        start, bit_valid, out_ready, busy, out_valid;
    logic [1:0]  mode;
    logic [3:0]  bit_in;
    logic [31:0] sum_out;

    // Small instance: N=4, C=1, OW=4
    logic        s_start, s_bit_valid, s_out_ready, s_busy, s_out_valid;
    logic [1:0]  s_mode;
    logic [0:0]  s_bit_in;
    logic [3:0]  s_sum_out;

    // Large instance: N=256, C=8, OW=10
    logic        l_start, l_bit_valid, l_out_ready, l_busy, l_out_valid;
    logic [1:0]  l_mode;
    logic [7:0]  l_bit_in;
    logic [79:0] l_sum_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_popcount_offset_converter #(.SERIAL_INPUT_LENGTH(64), .NUM_CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_in(bit_in),
        .bit_valid(bit_valid), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .sum_out(sum_out));

    serial_popcount_offset_converter #(.SERIAL_INPUT_LENGTH(4), .NUM_CHANNELS(1)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .bit_in(s_bit_in),
        .bit_valid(s_bit_valid), .busy(s_busy), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .sum_out(s_sum_out));

    serial_popcount_offset_converter #(.SERIAL_INPUT_LENGTH(256), .NUM_CHANNELS(8)) dut_large (
        .clk(clk), .rst(rst), .start(l_start), .mode(l_mode), .bit_in(l_bit_in),
        .bit_valid(l_bit_valid), .busy(l_busy), .out_valid(l_out_valid),
        .out_ready(l_out_ready), .sum_out(l_sum_out));

    // Channel patterns, channel 0 in the low 64 bits.
    localparam logic [255:0] PATS_A = {64'h0000_0000_0000_0001, 64'h5555_5555_5555_5555,
                                       64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [255:0] PATS_B = {64'h0000_00FF_FFFF_FFFF, 64'h5555_5555_5555_5555,
                                       64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [255:0] PATS_ONES = {4{64'hFFFF_FFFF_FFFF_FFFF}};

    typedef struct {
        string        name;
        logic [1:0]   md;
        logic [255:0] pats;
        int           exp [4];
    } vec_t;

    // Reference mapping of a ones count to the signed result.
    function automatic int offset_model(input int cnt, input int md, input int n);
        if (md == 1) return cnt - n / 2;
        else if (md == 2) return 2 * cnt - n;
        else return cnt;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lane(input int ch);
        logic signed [7:0] v;
        v = sum_out[ch*8 +: 8];
        return int'(v);
    endfunction

    task automatic open_frame(input logic [1:0] md);
        start = 1'b1;
        mode  = md;
        tick();
        start = 1'b0;
        check("open_busy", int'(busy), 1);
        check("open_out_valid", int'(out_valid), 0);
    endtask

    // Presents nbits valid bits (optionally with random gaps and mode noise).
    task automatic send_bits(input logic [255:0] pats, input bit gaps,
                             input bit toggle, input int nbits);
        int b = 0;
        int cyc = 0;
        while (b < nbits && cyc < 400) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bit_valid = 1'b0;
                bit_in    = 4'($urandom);
            end else begin
                bit_valid = 1'b1;
                for (int ch = 0; ch < 4; ch++) bit_in[ch] = pats[ch*64 + b];
            end
            if (toggle) mode = 2'($urandom);
            tick();
            cyc++;
            if (bit_valid) b++;
            if (b < 64) check("out_valid_early", int'(out_valid), 0);
        end
        bit_valid = 1'b0;
        bit_in    = 4'b0000;
        if (b != nbits) check("bit_send_timeout", b, nbits);
    endtask

    task automatic check_model(input string tag, input int md, input logic [255:0] pats);
        check({tag, "_out_valid"}, int'(out_valid), 1);
        for (int ch = 0; ch < 4; ch++)
            check(tag, lane(ch), offset_model($countones(pats[ch*64 +: 64]), md, 64));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_out_valid", int'(out_valid), 0);
        check("hs_busy", int'(busy), 0);
    endtask

    initial begin
        vec_t         vecs [4];
        logic [255:0] rp;
        logic [1:0]   rm;
        logic [31:0]  held;
        logic [3:0]   spats [4];
        int           lmodes [5];
        int           lkinds [5];
        int           lcnt [8];
        logic [7:0]   lv;
        logic signed [3:0] sv;
        logic signed [9:0] lsv;
        int           scnt;

        vecs[0].name = "m01_a";  vecs[0].md = 2'b01; vecs[0].pats = PATS_A; vecs[0].exp = '{32, -32, 0, -31};
        vecs[1].name = "m10_b";  vecs[1].md = 2'b10; vecs[1].pats = PATS_B; vecs[1].exp = '{64, -64, 0, 16};
        vecs[2].name = "m00_b";  vecs[2].md = 2'b00; vecs[2].pats = PATS_B; vecs[2].exp = '{64, 0, 32, 40};
        vecs[3].name = "m11_b";  vecs[3].md = 2'b11; vecs[3].pats = PATS_B; vecs[3].exp = '{64, 0, 32, 40};
        spats  = '{4'hF, 4'h0, 4'h5, 4'h8};
        lmodes = '{0, 1, 2, 2, 1};
        lkinds = '{0, 0, 1, 2, 2};

        rst = 1'b1;
        start = 1'b0; mode = 2'b00; bit_in = 4'b0; bit_valid = 1'b0; out_ready = 1'b0;
        s_start = 1'b0; s_mode = 2'b00; s_bit_in = 1'b0; s_bit_valid = 1'b0; s_out_ready = 1'b0;
        l_start = 1'b0; l_mode = 2'b00; l_bit_in = 8'b0; l_bit_valid = 1'b0; l_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sum", int'(sum_out), 0);
        check("rst_small", int'({s_busy, s_out_valid, s_sum_out}), 0);
        check("rst_large", int'(l_sum_out != 80'd0) + int'(l_busy) + int'(l_out_valid), 0);

        // Directed table vectors, contiguous valid bits.
        for (int v = 0; v < 4; v++) begin
            open_frame(vecs[v].md);
            send_bits(vecs[v].pats, 1'b0, 1'b0, 64);
            check({vecs[v].name, "_out_valid"}, int'(out_valid), 1);
            check({vecs[v].name, "_busy"}, int'(busy), 1);
            for (int ch = 0; ch < 4; ch++) check(vecs[v].name, lane(ch), vecs[v].exp[ch]);
            handshake();
        end

        // Gapped valid bits with mode noise: must match the contiguous mode-01 run.
        open_frame(2'b01);
        send_bits(PATS_A, 1'b1, 1'b1, 64);
        check("gap_out_valid", int'(out_valid), 1);
        for (int ch = 0; ch < 4; ch++) check("gap_sum", lane(ch), vecs[0].exp[ch]);
        handshake();

        // Randomized frames against the reference model.
        for (int f = 0; f < 6; f++) begin
            rp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rm = 2'($urandom);
            open_frame(rm);
            send_bits(rp, 1'($urandom), 1'b1, 64);
            check_model("rand_sum", int'(rm), rp);
            handshake();
        end

        // Backpressure in HOLD, then back-to-back frame open on the handshake.
        open_frame(2'b10);
        send_bits(PATS_B, 1'b0, 1'b0, 64);
        held = sum_out;
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b0; start = 1'b1; bit_valid = 1'b1;
            mode = 2'($urandom); bit_in = 4'($urandom);
            tick();
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_busy", int'(busy), 1);
            check("bp_sum_stable", int'(sum_out), int'(held));
        end
        bit_valid = 1'b0; out_ready = 1'b1; start = 1'b1; mode = 2'b01;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("b2b_busy", int'(busy), 1);
        check("b2b_out_valid", int'(out_valid), 0);
        check("b2b_sum_kept", int'(sum_out), int'(held));
        send_bits(PATS_ONES, 1'b0, 1'b0, 64);
        check_model("b2b_sum", 1, PATS_ONES);
        handshake();

        // Reset after 20 valid bits discards the frame.
        open_frame(2'b01);
        send_bits(PATS_B, 1'b0, 1'b0, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_sum", int'(sum_out), 0);
        open_frame(2'b01);
        send_bits(PATS_ONES, 1'b0, 1'b0, 64);
        for (int ch = 0; ch < 4; ch++) check("post_rst_sum", lane(ch), 32);
        handshake();

        // N=4, C=1 end points in every mode.
        for (int md = 0; md < 4; md++) begin
            for (int p = 0; p < 4; p++) begin
                s_start = 1'b1; s_mode = 2'(md);
                tick();
                s_start = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    s_bit_valid = 1'b1; s_bit_in[0] = spats[p][b];
                    tick();
                end
                s_bit_valid = 1'b0;
                scnt = $countones(spats[p]);
                sv = s_sum_out;
                check("n4_out_valid", int'(s_out_valid), 1);
                check("n4_sum", int'(sv), offset_model(scnt, md, 4));
                if (md == 2 && scnt == 4) check("n4_bipolar_full", int'(sv), 4);
                s_out_ready = 1'b1;
                tick();
                s_out_ready = 1'b0;
                check("n4_hs", int'(s_out_valid), 0);
            end
        end

        // N=256, C=8 frames including full-scale bipolar end points.
        for (int f = 0; f < 5; f++) begin
            l_start = 1'b1; l_mode = 2'(lmodes[f]);
            tick();
            l_start = 1'b0;
            for (int ch = 0; ch < 8; ch++) lcnt[ch] = 0;
            for (int b = 0; b < 256; b++) begin
                lv = (lkinds[f] == 0) ? 8'($urandom) : ((lkinds[f] == 1) ? 8'hFF : 8'h00);
                for (int ch = 0; ch < 8; ch++) lcnt[ch] += int'(lv[ch]);
                l_bit_valid = 1'b1; l_bit_in = lv;
                tick();
            end
            l_bit_valid = 1'b0;
            check("n256_out_valid", int'(l_out_valid), 1);
            for (int ch = 0; ch < 8; ch++) begin
                lsv = l_sum_out[ch*10 +: 10];
                check("n256_sum", int'(lsv), offset_model(lcnt[ch], lmodes[f], 256));
            end
            lsv = l_sum_out[9:0];
            if (lmodes[f] == 2 && lkinds[f] == 1) check("n256_bipolar_max", int'(lsv), 256);
            if (lmodes[f] == 2 && lkinds[f] == 2) check("n256_bipolar_min", int'(lsv), -256);
            l_out_ready = 1'b1;
            tick();
            l_out_ready = 1'b0;
            check("n256_hs", int'(l_out_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_popcount_offset_converter.md
# serial_popcount_offset_converter

Multi-channel, bit-serial thermometer-to-two's-complement converter. Each channel counts the ones in a serial frame of SERIAL_INPUT_LENGTH valid bits, then applies a selectable offset: raw count, mid-scale offset, or bipolar mapping. The result is a signed word per channel. The block sits between the serial partial-product streams and the partial-product adder tree, and presents all channels together on a valid/ready output.

## Interface
Parameters:
- SERIAL_INPUT_LENGTH, 64: frame length N in valid bits. Must be a power of two, at least 4.
- NUM_CHANNELS, 4: number of parallel serial channels C.
- Derived: CW = $clog2(N); count width = CW+1; OW = CW+2 (signed output width per channel).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  single-cycle pulse that opens a frame. It also latches mode.
- mode  in  2  offset mode. 00 raw; 01 mid-scale; 10 bipolar; 11 treated as 00.
- bit_in  in  C  one serial bit per channel.
- bit_valid  in  1  qualifies bit_in for all channels.
- busy  out  1  high in ACCUM and HOLD.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- sum_out  out  C*OW  channel i occupies [i*OW +: OW]; two's complement.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1: clear all channel counts, clear bit counter, latch mode, go to ACCUM.
  - bit_valid is ignored.
- ACCUM:
  - Each cycle with bit_valid=1: count[i] += bit_in[i] for every channel; bit counter += 1.
  - Cycles with bit_valid=0 change nothing.
  - On the N-th valid bit (bit counter == N-1 while bit_valid=1), include that bit. Register sum_out from the final counts and go to HOLD.
  - start is ignored. mode changes are ignored.
- Offset arithmetic, per channel, with cnt zero-extended to OW bits signed:
  - Mode 00: sum = cnt. Range 0..N.
  - Mode 01: sum = cnt − 2^(CW−1). Range −N/2..+N/2.
  - Mode 10: sum = 2·cnt − N. Range −N..+N.
  - OW bits holds every case exactly; no saturation or overflow logic is required.
- HOLD:
  - out_valid=1. sum_out and busy are held stable.
  - bit_valid and mode are ignored.
  - out_ready=1 completes the handshake. With start=0, go to IDLE. With start=1 in the same cycle, go straight to ACCUM with a fresh clear and mode latch (back-to-back frames).
- sum_out keeps the last result after the handshake until the next frame completes.

## Timing
- Reset (rst=1 at a clock edge) from any state:
  - State goes to IDLE.
  - busy=0, out_valid=0, sum_out=0.
  - Counts, bit counter and latched mode are cleared.
- A reset in the middle of a frame discards the partial frame; no output is produced.
- busy rises the cycle after start is sampled in IDLE.
- out_valid rises on the edge that samples the N-th valid bit, i.e. one cycle after that bit is presented. Minimum frame time is start + N cycles.
- out_valid falls on the edge that samples out_valid & out_ready.
- Throughput: one frame every N+1 cycles when start coincides with the handshake. There is no bubble beyond the HOLD cycle.
- rst has priority over start, bit_valid and out_ready.

## Test plan
- N=64, C=4, mode 01:
  - Stimulus: 64 contiguous valid bits. ch0 all ones; ch1 all zeros; ch2 alternating 1/0 (32 ones); ch3 a single one.
  - Response: sum_out = +32, −32, 0, −31. out_valid exactly 1 cycle after the 64th bit.
- Mode 10, same lane pattern except ch3 has 40 ones:
  - Response: +64, −64, 0, +16.
  - Mode 00 on the same data: 64, 0, 32, 40.
- bit_valid gaps:
  - Stimulus: 64 valid bits spread over 100 cycles with random gaps; mode toggled during ACCUM.
  - Response: results identical to the contiguous run; the mode latched at start is used.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in HOLD while driving start and bit_valid.
  - Response: sum_out stable, out_valid=1, no state change.
  - Then assert out_ready=1 and start=1 in the same cycle: next cycle state is ACCUM, busy=1, out_valid=0.
- Reset mid-frame:
  - Stimulus: assert rst after 20 valid bits.
  - Response: next cycle busy=0, out_valid=0, sum_out=0.
  - A following full frame of all ones in mode 01 gives +32 on every channel; no residue from the aborted frame.
- Parameter sweep: N=4 with C=1, and N=256 with C=8.
  - Check end-point values in all modes, e.g. N=4 mode 10 with all ones → +4 in OW=4 bits.
